pwm_breathe_ctrl: RTL and testbench

Downstream consumer of the 16-bit free-running counter, which supplies count value q and the one-cycle rollover pulse.
- Compares the count against an internal duty register to produce a PWM output.
- On each counter rollover, steps the duty through a rise / hold-high / fall / hold-low sequence, giving a "breathing" LED drive.
- Sits between the counter and the board LED pin on the SmartFusion2 top level.

---
 rtl/pwm_breathe_pkg.sv | 36 +++
 rtl/pwm_breathe_ctrl_compare.sv | 30 +++
 rtl/pwm_breathe_ctrl.sv | 133 +++++++++++++
 tb/tb_pwm_breathe_ctrl.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/pwm_breathe_pkg.sv
// Shared definitions for the breathing-LED PWM controller: phase codes,
// internal state type and parameter defaults.
package pwm_breathe_pkg;

   localparam int unsigned DEF_N            = 16;
   localparam int unsigned DEF_STEP         = 4096;
   localparam int unsigned DEF_MAX_DUTY     = 65535;
   localparam int unsigned DEF_HOLD_PERIODS = 4;

   localparam logic [1:0] PH_IDLE    = 2'd0;
   localparam logic [1:0] PH_RISE    = 2'd1;
   localparam logic [1:0] PH_HOLD_HI = 2'd2;
   localparam logic [1:0] PH_FALL    = 2'd3;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RISE,
      ST_HOLD_HI,
      ST_FALL,
      ST_HOLD_LO
   } state_e;

   // HOLD_LO is externally indistinguishable from IDLE on the phase port.
   function automatic logic [1:0] state_to_phase(input state_e s);
      logic [1:0] ph;
      ph = PH_IDLE;
      case (s)
         ST_RISE:    ph = PH_RISE;
         ST_HOLD_HI: ph = PH_HOLD_HI;
         ST_FALL:    ph = PH_FALL;
         default:    ph = PH_IDLE;
      endcase
      return ph;
   endfunction

endpackage

// File: rtl/pwm_breathe_ctrl_compare.sv
// Registered N-bit comparator producing the PWM drive, gated by enable.
module pwm_compare #(
   parameter int unsigned N = 16
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         en,
   input  logic [N-1:0] q_in,
   input  logic [N-1:0] duty,
   output logic         pwm_out
);

   logic pwm_d;
   logic pwm_q;

   always_comb begin
      pwm_d = en && (q_in < duty);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pwm_q <= 1'b0;
      end else begin
         pwm_q <= pwm_d;
      end
   end

   assign pwm_out = pwm_q;

endmodule

// File: rtl/pwm_breathe_ctrl.sv
// Breathing-LED controller: steps a duty register through rise / hold-high /
// fall / hold-low on each counter rollover and drives a registered PWM output.
module pwm_breathe_ctrl
   import pwm_breathe_pkg::*;
#(
   parameter int unsigned N            = DEF_N,
   parameter int unsigned STEP         = DEF_STEP,
   parameter int unsigned MAX_DUTY     = DEF_MAX_DUTY,
   parameter int unsigned HOLD_PERIODS = DEF_HOLD_PERIODS
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [N-1:0] q_in,
   input  logic         rollover_in,
   input  logic         enable,
   output logic         pwm_out,
   output logic [N-1:0] duty,
   output logic [1:0]   phase,
   output logic         cycle_done
);

   localparam logic [N:0] STEP_W    = (N+1)'(STEP);
   localparam logic [N:0] MAX_W     = (N+1)'(MAX_DUTY);
   localparam logic [7:0] HOLD_LAST = 8'(HOLD_PERIODS - 1);

   state_e       state_d, state_q;
   logic [N-1:0] duty_d,  duty_q;
   logic [7:0]   hold_d,  hold_q;
   logic         done_d,  done_q;
   logic [N:0]   sum_w;

   // One extra bit on the sum so saturation is detected before any wrap.
   always_comb begin
      state_d = state_q;
      duty_d  = duty_q;
      hold_d  = hold_q;
      done_d  = 1'b0;
      sum_w   = {1'b0, duty_q} + STEP_W;

      if (!enable) begin
         state_d = ST_IDLE;
         duty_d  = '0;
         hold_d  = '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               state_d = ST_RISE;
               duty_d  = '0;
               hold_d  = '0;
            end
            ST_RISE: begin
               if (rollover_in) begin
                  if (sum_w >= MAX_W) begin
                     duty_d  = MAX_W[N-1:0];
                     hold_d  = '0;
                     state_d = ST_HOLD_HI;
                  end else begin
                     duty_d = sum_w[N-1:0];
                  end
               end
            end
            ST_HOLD_HI: begin
               if (rollover_in) begin
                  if (hold_q == HOLD_LAST) begin
                     hold_d  = '0;
                     state_d = ST_FALL;
                  end else begin
                     hold_d = hold_q + 8'd1;
                  end
               end
            end
            ST_FALL: begin
               if (rollover_in) begin
                  if ({1'b0, duty_q} <= STEP_W) begin
                     duty_d  = '0;
                     hold_d  = '0;
                     state_d = ST_HOLD_LO;
                  end else begin
                     duty_d = duty_q - STEP_W[N-1:0];
                  end
               end
            end
            ST_HOLD_LO: begin
               if (rollover_in) begin
                  if (hold_q == HOLD_LAST) begin
                     hold_d  = '0;
                     state_d = ST_RISE;
                     done_d  = 1'b1;
                  end else begin
                     hold_d = hold_q + 8'd1;
                  end
               end
            end
            default: begin
               state_d = ST_IDLE;
               duty_d  = '0;
               hold_d  = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         duty_q  <= '0;
         hold_q  <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         duty_q  <= duty_d;
         hold_q  <= hold_d;
         done_q  <= done_d;
      end
   end

   // Compares against the pre-update duty, so a step lands at the next q_in=0.
   pwm_compare #(
      .N(N)
   ) u_compare (
      .clk     (clk),
      .rst_n   (rst_n),
      .en      (enable),
      .q_in    (q_in),
      .duty    (duty_q),
      .pwm_out (pwm_out)
   );

   assign duty       = duty_q;
   assign phase      = state_to_phase(state_q);
   assign cycle_done = done_q;

endmodule

// File: tb/tb_pwm_breathe_ctrl.sv
// Self-checking bench: three parameterisations share one stimulus stream and
// are compared every cycle against an arithmetic model plus literal checkpoints.
module tb_pwm_breathe_ctrl;

   localparam int P_STEP[3] = '{16384, 5000, 4096};
   localparam int P_MAX[3]  = '{65535, 12000, 65535};
   localparam int P_HOLD[3] = '{2, 3, 4};

   logic        clk = 1'b0;
   logic        rst_n;
   logic [15:0] q_in;
   logic        rollover_in;
   logic        enable;

   logic        pwm_a, pwm_b, pwm_c;
   logic [15:0] duty_a, duty_b, duty_c;
   logic [1:0]  phase_a, phase_b, phase_c;
   logic        done_a, done_b, done_c;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   pwm_breathe_ctrl #(.N(16), .STEP(16384), .MAX_DUTY(65535), .HOLD_PERIODS(2)) u_a (
      .clk(clk), .rst_n(rst_n), .q_in(q_in), .rollover_in(rollover_in), .enable(enable),
      .pwm_out(pwm_a), .duty(duty_a), .phase(phase_a), .cycle_done(done_a));

   pwm_breathe_ctrl #(.N(16), .STEP(5000), .MAX_DUTY(12000), .HOLD_PERIODS(3)) u_b (
      .clk(clk), .rst_n(rst_n), .q_in(q_in), .rollover_in(rollover_in), .enable(enable),
      .pwm_out(pwm_b), .duty(duty_b), .phase(phase_b), .cycle_done(done_b));

   pwm_breathe_ctrl #(.N(16), .STEP(4096), .MAX_DUTY(65535), .HOLD_PERIODS(4)) u_c (
      .clk(clk), .rst_n(rst_n), .q_in(q_in), .rollover_in(rollover_in), .enable(enable),
      .pwm_out(pwm_c), .duty(duty_c), .phase(phase_c), .cycle_done(done_c));

   logic        act_pwm[3];
   logic [15:0] act_duty[3];
   logic [1:0]  act_phase[3];
   logic        act_done[3];
   assign act_pwm[0] = pwm_a;   assign act_pwm[1] = pwm_b;   assign act_pwm[2] = pwm_c;
   assign act_duty[0] = duty_a; assign act_duty[1] = duty_b; assign act_duty[2] = duty_c;
   assign act_phase[0] = phase_a; assign act_phase[1] = phase_b; assign act_phase[2] = phase_c;
   assign act_done[0] = done_a; assign act_done[1] = done_b; assign act_done[2] = done_c;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Model: seg 0=off, 1=rising, 2=holding high, 3=falling, 4=holding low.
   int m_seg[3]  = '{0, 0, 0};
   int m_duty[3] = '{0, 0, 0};
   int m_hold[3] = '{0, 0, 0};
   int m_pwm[3]  = '{0, 0, 0};
   int m_done[3] = '{0, 0, 0};

   always @(posedge clk or negedge rst_n) begin
      for (int k = 0; k < 3; k++) begin
         if (!rst_n) begin
            m_seg[k] = 0; m_duty[k] = 0; m_hold[k] = 0; m_pwm[k] = 0; m_done[k] = 0;
         end else begin
            m_pwm[k]  = (enable && (int'(q_in) < m_duty[k])) ? 1 : 0;
            m_done[k] = 0;
            if (!enable) begin
               m_seg[k] = 0; m_duty[k] = 0; m_hold[k] = 0;
            end else if (m_seg[k] == 0) begin
               m_seg[k] = 1;
            end else if (rollover_in) begin
               case (m_seg[k])
                  1: if (m_duty[k] + P_STEP[k] >= P_MAX[k]) begin
                        m_duty[k] = P_MAX[k]; m_hold[k] = 0; m_seg[k] = 2;
                     end else m_duty[k] = m_duty[k] + P_STEP[k];
                  2: if (m_hold[k] == P_HOLD[k] - 1) begin
                        m_hold[k] = 0; m_seg[k] = 3;
                     end else m_hold[k]++;
                  3: if (m_duty[k] <= P_STEP[k]) begin
                        m_duty[k] = 0; m_seg[k] = 4;
                     end else m_duty[k] = m_duty[k] - P_STEP[k];
                  default: if (m_hold[k] == P_HOLD[k] - 1) begin
                        m_hold[k] = 0; m_seg[k] = 1; m_done[k] = 1;
                     end else m_hold[k]++;
               endcase
            end
         end
      end
   end

   always @(posedge clk) begin
      #1;
      for (int k = 0; k < 3; k++) begin
         chk($sformatf("model_pwm%0d", k),   int'(act_pwm[k]),   m_pwm[k]);
         chk($sformatf("model_duty%0d", k),  int'(act_duty[k]),  m_duty[k]);
         chk($sformatf("model_phase%0d", k), int'(act_phase[k]), (m_seg[k] == 4) ? 0 : m_seg[k]);
         chk($sformatf("model_done%0d", k),  int'(act_done[k]),  m_done[k]);
      end
   end

   task automatic cyc(input logic [15:0] q, input logic ro, input logic en);
      @(negedge clk);
      q_in = q; rollover_in = ro; enable = en;
      @(posedge clk);
      #2;
   endtask

   task automatic roll();
      cyc(16'hFFFF, 1'b1, 1'b1);
   endtask

   task automatic filler(input int n);
      for (int i = 0; i < n; i++) cyc(16'($urandom_range(0, 65534)), 1'b0, 1'b1);
   endtask

   int exp_da[12] = '{16384, 32768, 49152, 65535, 65535, 65535, 49151, 32767, 16383, 0, 0, 0};
   int exp_pa[12] = '{1, 1, 1, 2, 2, 3, 3, 3, 3, 0, 0, 1};
   int exp_db[12] = '{5000, 10000, 12000, 12000, 12000, 12000, 7000, 2000, 0, 0, 0, 0};
   int exp_pb[12] = '{1, 1, 2, 2, 2, 3, 3, 3, 0, 0, 0, 1};

   initial begin
      int hi;
      rst_n = 1'b0; enable = 1'b0; q_in = '0; rollover_in = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      chk("reset_duty", int'(duty_a), 0);
      chk("reset_pwm", int'(pwm_a), 0);
      chk("reset_phase", int'(phase_a), 0);
      chk("reset_done", int'(done_a), 0);

      @(negedge clk); rst_n = 1'b1; enable = 1'b1;
      @(posedge clk); #2;
      chk("start_phase", int'(phase_a), 1);

      hi = 0;
      for (int i = 0; i < 20; i++) begin
         cyc(16'($urandom_range(0, 65534)), 1'b0, 1'b1);
         if (pwm_a) hi++;
      end
      chk("duty0_pwm_high", hi, 0);

      roll();
      chk("rise1_duty_a", int'(duty_a), 16384);
      chk("rise1_duty_b", int'(duty_b), 5000);

      hi = 0;
      for (int i = 0; i < 65536; i++) begin
         cyc(16'(i), (i == 65535), 1'b1);
         if (pwm_a) hi++;
      end
      chk("sweep_pwm_high", hi, 16384);
      chk("rise2_duty_a", int'(duty_a), 32768);
      chk("rise2_duty_b", int'(duty_b), 10000);

      cyc(16'hFFFF, 1'b1, 1'b0);
      chk("endrop_duty_a", int'(duty_a), 0);
      chk("endrop_phase_a", int'(phase_a), 0);
      chk("endrop_done_a", int'(done_a), 0);
      chk("endrop_pwm_a", int'(pwm_a), 0);
      cyc(16'd3, 1'b0, 1'b1);
      chk("reenable_phase_a", int'(phase_a), 1);
      filler(2);

      for (int r = 0; r < 12; r++) begin
         roll();
         chk($sformatf("breath%0d_duty_a", r + 1), int'(duty_a), exp_da[r]);
         chk($sformatf("breath%0d_phase_a", r + 1), int'(phase_a), exp_pa[r]);
         chk($sformatf("breath%0d_duty_b", r + 1), int'(duty_b), exp_db[r]);
         chk($sformatf("breath%0d_phase_b", r + 1), int'(phase_b), exp_pb[r]);
         chk($sformatf("breath%0d_done_a", r + 1), int'(done_a), (r == 11) ? 1 : 0);
         filler(1);
         if (r == 11) begin
            chk("done_a_drops", int'(done_a), 0);
            chk("done_b_drops", int'(done_b), 0);
         end
         filler(2);
      end

      for (int r = 0; r < 8; r++) begin
         roll();
         filler(2);
      end
      cyc(16'd0, 1'b0, 1'b1);
      chk("prereset_duty_a", int'(duty_a), 32767);
      chk("prereset_phase_a", int'(phase_a), 3);
      chk("prereset_pwm_a", int'(pwm_a), 1);

      @(negedge clk); #1;
      rst_n = 1'b0;
      #1;
      chk("async_duty_a", int'(duty_a), 0);
      chk("async_pwm_a", int'(pwm_a), 0);
      chk("async_phase_a", int'(phase_a), 0);
      chk("async_done_a", int'(done_a), 0);
      @(negedge clk); rst_n = 1'b1; enable = 1'b1; q_in = '0; rollover_in = 1'b0;
      @(posedge clk); #2;
      chk("release_phase_a", int'(phase_a), 1);
      filler(3);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #1500000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog expired");
   end

endmodule
